// File: rtl/age_arb_pkg.sv
// Shared definitions for the three-way age-based arbiter.
package age_arb_pkg;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned CNT_WIDTH = 4;  // holds OCCUPANCY-2 for OCCUPANCY up to 15

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StBusy  = 2'd2
   } state_t;

   typedef logic [1:0] src_idx_t;

endpackage

// File: rtl/age_select3.sv
// Picks the oldest valid requester; equal ages resolve to the lowest index.
module age_select3
   import age_arb_pkg::*;
#(
   parameter int unsigned AGE_WIDTH = 4
) (
   input  logic [AGE_WIDTH-1:0] i_age [NUM_REQ-1:0],
   input  logic [NUM_REQ-1:0]   i_valid,
   output logic [NUM_REQ-1:0]   o_sel,
   output src_idx_t             o_idx
);

   logic                 w_found;
   logic [AGE_WIDTH-1:0] w_best_age;

   // Scan upward; strict '>' keeps the earlier index on a tie.
   always_comb begin
      w_found    = 1'b0;
      w_best_age = '0;
      o_idx      = '0;
      o_sel      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_valid[i] && (!w_found || (i_age[i] > w_best_age))) begin
            w_found    = 1'b1;
            w_best_age = i_age[i];
            o_idx      = src_idx_t'(i);
         end
      end
      if (w_found) begin
         o_sel = {{(NUM_REQ-1){1'b0}}, 1'b1} << o_idx;
      end
   end

endmodule

// File: rtl/age_arbiter_3way.sv
// Three-requester arbiter granting the longest-waiting request into a shared
// unit that stays occupied for OCCUPANCY cycles after each accepted issue.
module age_arbiter_3way
   import age_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned AGE_WIDTH  = 4,
   parameter int unsigned OCCUPANCY  = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ-1:0],
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_src,
   output logic                  busy
);

   localparam logic [AGE_WIDTH-1:0] AgeMax = '1;

   state_t                r_state, w_state_d;
   logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
   logic [AGE_WIDTH-1:0]  r_age [NUM_REQ-1:0];
   logic [DATA_WIDTH-1:0] r_out_data;
   src_idx_t              r_out_src;

   logic [NUM_REQ-1:0]    w_sel;
   src_idx_t              w_idx;
   logic                  w_hs;

   age_select3 #(
      .AGE_WIDTH (AGE_WIDTH)
   ) u_select (
      .i_age   (r_age),
      .i_valid (req_valid),
      .o_sel   (w_sel),
      .o_idx   (w_idx)
   );

   // Next-state, down-counter and handshake outputs.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      req_ready = '0;
      out_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            // Gated by reset so no accept is advertised while held in reset.
            if (reset_n) begin
               req_ready = w_sel;
            end
            if (|w_sel) begin
               w_state_d = StIssue;
            end
         end
         StIssue: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (OCCUPANCY == 1) begin
                  w_state_d = StIdle;
               end else begin
                  w_state_d = StBusy;
                  w_cnt_d   = CNT_WIDTH'(OCCUPANCY - 2);
               end
            end
         end
         StBusy: begin
            if (r_cnt == '0) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign w_hs     = |req_ready;
   assign busy     = (r_state != StIdle);
   assign out_data = r_out_data;
   assign out_src  = r_out_src;

   // State, busy counter and issued payload registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_out_data <= '0;
         r_out_src  <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_hs) begin
            r_out_data <= req_data[w_idx];
            r_out_src  <= w_idx;
         end
      end
   end

   // Per-requester wait age: zero when idle or accepted, saturating otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_age[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || req_ready[i]) begin
               r_age[i] <= '0;
            end else if (r_age[i] != AgeMax) begin
               r_age[i] <= r_age[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_age_arbiter_3way.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a cycle-count based reference model.
module tb_age_arbiter_3way;

   localparam int DW  = 8;
   localparam int AW  = 2;
   localparam int OCC = 2;
   localparam int AGE_MAX = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    req_valid;
   logic [DW-1:0] req_data [2:0];
   logic [2:0]    req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    out_src;
   logic          busy;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int       m_age [3];
   bit       m_pend;
   int       m_data;
   int       m_src;
   int       m_cyc;
   int       m_allow;

   logic [2:0]    last_ready;
   logic          last_ov;
   logic [DW-1:0] last_data;
   logic [1:0]    last_src;

   age_arbiter_3way #(
      .DATA_WIDTH (DW),
      .AGE_WIDTH  (AW),
      .OCCUPANCY  (OCC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_age[i] = 0;
      m_pend  = 0;
      m_allow = m_cyc;
   endtask

   // One clock cycle: check outputs against the model, advance the model,
   // then let granted requesters withdraw their request.
   task automatic step();
      logic [2:0] er;
      int best;
      #1;
      er   = '0;
      best = -1;
      if (!m_pend && m_cyc >= m_allow) begin
         for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && (best < 0 || m_age[i] > m_age[best])) best = i;
         end
      end
      if (best >= 0) er[best] = 1'b1;
      last_ready = req_ready;
      last_ov    = out_valid;
      last_data  = out_data;
      last_src   = out_src;
      check("req_ready", 32'(req_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(m_pend));
      check("busy", 32'(busy), 32'(m_pend || (m_cyc < m_allow)));
      if (m_pend) begin
         check("out_data", 32'(out_data), 32'(m_data));
         check("out_src", 32'(out_src), 32'(m_src));
      end
      if (m_pend && out_ready) begin
         m_pend  = 0;
         m_allow = m_cyc + OCC;
      end
      if (best >= 0) begin
         m_pend = 1;
         m_data = int'(req_data[best]);
         m_src  = best;
      end
      for (int i = 0; i < 3; i++) begin
         if (!req_valid[i] || er[i]) m_age[i] = 0;
         else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
      end
      m_cyc++;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~er;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) req_data[i] = '0;
      m_cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      reset_n = 1'b1;

      // Single request from requester 1
      out_ready   = 1'b1;
      req_valid   = 3'b010;
      req_data[1] = 8'hA5;
      step();
      check("single_ready", 32'(last_ready), 32'h2);
      step();
      check("single_ov", 32'(last_ov), 1);
      check("single_data", 32'(last_data), 32'hA5);
      check("single_src", 32'(last_src), 1);
      steps(2);

      // Three-way tie: grants 0,1,2 three cycles apart
      req_data[0] = 8'h10; req_data[1] = 8'h11; req_data[2] = 8'h12;
      req_valid   = 3'b111;
      for (int k = 0; k < 9; k++) begin
         step();
         check("tie_grant", 32'(last_ready), (k % 3 == 0) ? (32'h1 << (k / 3)) : 0);
      end
      steps(1);

      // Aging under backpressure: req 2 waits, later req 0 loses to it
      out_ready   = 1'b0;
      req_valid   = 3'b001;
      req_data[0] = 8'h21;
      step();
      req_valid   = 3'b100;
      req_data[2] = 8'h22;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_ov", 32'(last_ov), 1);
         check("bp_data", 32'(last_data), 32'h21);
         check("bp_ready", 32'(last_ready), 0);
      end
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h33;
      out_ready    = 1'b1;
      step();
      step();
      check("bp_gap", 32'(last_ready), 0);
      step();
      check("age_winner", 32'(last_ready), 32'h4);
      steps(6);

      // Saturation: both ages pinned at max, lower index wins
      out_ready   = 1'b0;
      req_valid   = 3'b100;
      req_data[2] = 8'h44;
      step();
      req_valid[1] = 1'b1;
      req_data[1]  = 8'h55;
      steps(6);
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h66;
      steps(4);
      out_ready = 1'b1;
      steps(2);
      step();
      check("sat_winner", 32'(last_ready), 32'h1);
      steps(8);

      // Reset while in ISSUE discards the payload
      req_valid   = 3'b001;
      req_data[0] = 8'h77;
      out_ready   = 1'b0;
      step();
      req_valid   = 3'b010;
      req_data[1] = 8'h88;
      reset_n     = 1'b0;
      #1;
      check("mid_rst_ov", 32'(out_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_ready", 32'(req_ready), 0);
      check("mid_rst_data", 32'(out_data), 0);
      model_reset();
      @(posedge clk);
      #1;
      m_cyc++;
      model_reset();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      step();
      check("post_rst_grant", 32'(last_ready), 32'h2);
      step();
      check("post_rst_data", 32'(last_data), 32'h88);
      steps(2);

      // Random traffic honouring the hold-until-ready rule
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (req_valid[i]) begin
               if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
               req_valid[i] = 1'b1;
               req_data[i]  = DW'($urandom);
            end
         end
         out_ready = ($urandom_range(2) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/age_arbiter_3way.md
AGE_ARBITER_3WAY -- requirements
Module: age_arbiter_3way

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload width per requester.
REQ-002 Parameter AGE_WIDTH, default 4, width of each saturating wait-age counter.
REQ-003 Parameter OCCUPANCY, default 2, cycles the shared unit stays busy after an accepted issue; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  [2:0]  per-requester request valid.
REQ-007 req_data  input  [DATA_WIDTH-1:0] x3 (unpacked [2:0])  per-requester payload.
REQ-008 req_ready  output  [2:0]  per-requester accept; at most one bit high per cycle.
REQ-009 out_valid  output  1  issued payload valid toward shared unit.
REQ-010 out_ready  input  1  shared unit accepts out_data.
REQ-011 out_data  output  DATA_WIDTH  registered payload of granted requester.
REQ-012 out_src  output  2  index (0..2) of granted requester; 3 never driven.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, ISSUE, BUSY; encoding from shared package.
REQ-015 Age: age[i] SHALL be 0 while req_valid[i] low, increment by 1 each cycle req_valid[i] high without req_ready[i], saturate at 2^AGE_WIDTH-1, clear to 0 on handshake.
REQ-016 Winner: requester with maximum age among valid requesters; ties go to lowest index.
REQ-017 In IDLE with any req_valid: req_ready[winner] SHALL be asserted combinationally in the same cycle; handshake completes that cycle.
REQ-018 On handshake: out_data <= req_data[winner], out_src <= winner, FSM -> ISSUE; out_valid high the following cycle (latency 1).
REQ-019 IDLE with no req_valid: req_ready all 0, FSM stays IDLE.
REQ-020 ISSUE: out_valid=1, out_data/out_src stable until out_ready; req_ready all 0.
REQ-021 ISSUE with out_ready: if OCCUPANCY=1 -> IDLE, else -> BUSY with down-counter loaded to OCCUPANCY-2.
REQ-022 BUSY: out_valid=0, req_ready all 0; -> IDLE when counter reaches 0, else decrement.
REQ-023 Net effect: out_ready handshake at cycle M permits next req_ready no earlier than cycle M+OCCUPANCY.
REQ-024 Requesters SHALL hold req_valid and req_data until req_ready; req_valid dropped early clears that age and is not an error.
REQ-025 Ages of non-winning requesters continue to increment during ISSUE and BUSY.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready; req_ready depends only on state, req_valid, ages.

Reset
REQ-027 reset_n low SHALL immediately force: FSM IDLE, all ages 0, busy counter 0, out_valid 0, out_data 0, out_src 0, req_ready 0.
REQ-028 Reset asserted mid-ISSUE or mid-BUSY discards the pending payload; no out_valid after release until a new handshake.
REQ-029 Reset deassertion SHALL be synchronised externally; first handshake is possible in the first cycle after release.

Structure
REQ-030 Package age_arb_pkg holds NUM_REQ=3, state enum (IDLE/ISSUE/BUSY), and source-index typedef (2 bits).
REQ-031 One combinational sub-module age_select3: inputs 3 ages + 3 valids, outputs one-hot select and 2-bit index, implementing REQ-016.
REQ-032 Age counters, FSM, output registers, busy counter live in age_arbiter_3way.

Verification
REQ-033 Single request: req_valid=3'b010, data[1]=8'hA5, out_ready=1 -> req_ready=3'b010 at cycle 0, out_valid with out_data=8'hA5, out_src=1 at cycle 1.
REQ-034 Tie: req_valid=3'b111 asserted together, ages 0 -> grant order 0,1,2 with OCCUPANCY=2, out_ready=1; grants spaced 3 cycles apart (grant, issue, busy).
REQ-035 Aging: req 2 waits 5 cycles then req 0 arrives while unit busy -> next grant to 2 (age 5+) before 0.
REQ-036 Backpressure: out_ready=0 for 4 cycles in ISSUE -> out_valid, out_data, out_src stable, req_ready 0 throughout; grant resumes OCCUPANCY cycles after out_ready.
REQ-037 Saturation: AGE_WIDTH=2, req 1 held 10 cycles -> age stays 3, no wrap; tie at 3 with req 0 -> req 0 wins.
REQ-038 Reset in ISSUE: reset_n low 1 cycle -> out_valid 0 immediately, ages 0, FSM IDLE; pending payload never delivered.
